vector_mac_reduction_tree: RTL and testbench

Fixed-point, fully pipelined N-lane multiply/adder-tree reduction with a packet accumulator: every valid beat multiplies two N-element vectors lane-wise and sums the products; beats are accumulated until `in_last`; one rounded, saturated scalar is emitted per packet. It is the parametrised successor of the floating-point reduction tree. It supports any N (not only powers of two), a runtime accumulate mode, saturation reporting and a beat count. It sits in the datapath wherever long dot products are split into N-wide chunks.

---
 rtl/vector_mac_reduction_tree.sv | 201 ++++++++++++++++++++
 tb/tb_vector_mac_reduction_tree.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mac_reduction_tree.sv
// +----------------------------------------------------------------------------+
// | vector_mac_reduction_tree                                                  |
// | N-lane fixed-point multiply, pipelined adder tree, packet accumulator,     |
// | round-half-up and saturate to one scalar per packet.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module vector_mac_reduction_tree #(
    parameter int BITWIDTH  = 16,
    parameter int N         = 8,
    parameter int FRAC      = 8,
    parameter int ACC_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N*BITWIDTH-1:0]   in0,
    input  logic [N*BITWIDTH-1:0]   in1,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    acc_en,
    output logic [BITWIDTH-1:0]     out,
    output logic                    out_valid,
    output logic                    out_sat,
    output logic [15:0]             out_beats
);

    localparam int c_levels = $clog2(N);
    localparam int c_np     = 1 << c_levels;
    localparam int c_sw     = 2 * BITWIDTH + c_levels;
    localparam int c_root   = c_levels + 1;

    localparam logic signed [ACC_WIDTH-1:0] c_half = ACC_WIDTH'(longint'(1) << (FRAC - 1));
    localparam logic signed [ACC_WIDTH-1:0] c_max  = ACC_WIDTH'((longint'(1) << (BITWIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_min  = -c_max - 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    logic [N*BITWIDTH-1:0]   r_a;
    logic [N*BITWIDTH-1:0]   r_b;
    logic                    r_v [0:c_root];
    logic                    r_l [0:c_root];
    logic                    r_m [0:c_root];
    logic signed [c_sw-1:0]  w_leaf [0:c_np-1];
    // Heap-ordered tree: node i sums nodes 2i and 2i+1, leaves at c_np..2*c_np-1.
    logic signed [c_sw-1:0]  r_tree [1:2*c_np-1];

    for (genvar j = 0; j < c_np; j++) begin : g_leaf
        if (j < N) begin : g_lane
            logic signed [2*BITWIDTH-1:0] w_x;
            logic signed [2*BITWIDTH-1:0] w_y;
            logic signed [2*BITWIDTH-1:0] w_p;
            assign w_x = {{BITWIDTH{r_a[j*BITWIDTH+BITWIDTH-1]}}, r_a[j*BITWIDTH +: BITWIDTH]};
            assign w_y = {{BITWIDTH{r_b[j*BITWIDTH+BITWIDTH-1]}}, r_b[j*BITWIDTH +: BITWIDTH]};
            assign w_p = w_x * w_y;
            assign w_leaf[j] = c_sw'(w_p);
        end else begin : g_pad
            assign w_leaf[j] = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a <= '0;
            r_b <= '0;
            for (int k = 0; k <= c_root; k++) begin
                r_v[k] <= 1'b0;
                r_l[k] <= 1'b0;
                r_m[k] <= 1'b0;
            end
            for (int i = 1; i < 2 * c_np; i++) begin
                r_tree[i] <= '0;
            end
        end else begin
            r_a    <= in0;
            r_b    <= in1;
            r_v[0] <= in_valid;
            r_l[0] <= in_last;
            r_m[0] <= acc_en;
            for (int k = 1; k <= c_root; k++) begin
                r_v[k] <= r_v[k-1];
                r_l[k] <= r_l[k-1];
                r_m[k] <= r_m[k-1];
            end
            for (int i = 1; i < c_np; i++) begin
                r_tree[i] <= r_tree[2*i] + r_tree[2*i+1];
            end
            for (int j = 0; j < c_np; j++) begin
                r_tree[c_np+j] <= w_leaf[j];
            end
        end
    end

    logic [0:0]                    r_state;
    logic [0:0]                    w_state_next;
    logic                          w_load;
    logic                          w_add;
    logic                          w_finish;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [15:0]                   r_beats;
    logic                          r_fin;

    assign w_sum = ACC_WIDTH'(r_tree[1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_v[c_root] && !r_l[c_root] && r_m[c_root]) begin
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (r_v[c_root] && r_l[c_root]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_add    = 1'b0;
        w_finish = 1'b0;
        if (r_v[c_root]) begin
            if (r_state == S_ACCUM) begin
                w_add    = 1'b1;
                w_finish = r_l[c_root];
            end else begin
                w_load   = 1'b1;
                w_finish = r_l[c_root] || !r_m[c_root];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc   <= '0;
            r_beats <= '0;
            r_fin   <= 1'b0;
        end else begin
            r_fin <= w_finish;
            if (w_load) begin
                r_acc   <= w_sum;
                r_beats <= 16'd1;
            end else if (w_add) begin
                r_acc <= r_acc + w_sum;
                if (r_beats != 16'hFFFF) begin
                    r_beats <= r_beats + 16'd1;
                end
            end
        end
    end

    // Output stage reads r_acc one cycle after finish, before a new packet can overwrite it.
    logic signed [ACC_WIDTH-1:0] w_rnd;
    logic signed [ACC_WIDTH-1:0] w_shr;
    logic                        w_hi;
    logic                        w_lo;

    assign w_rnd = r_acc + c_half;
    assign w_shr = w_rnd >>> FRAC;
    assign w_hi  = w_shr > c_max;
    assign w_lo  = w_shr < c_min;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_beats <= '0;
        end else begin
            out_valid <= r_fin;
            if (r_fin) begin
                out_sat   <= w_hi || w_lo;
                out_beats <= r_beats;
                if (w_hi) begin
                    out <= c_max[BITWIDTH-1:0];
                end else if (w_lo) begin
                    out <= c_min[BITWIDTH-1:0];
                end else begin
                    out <= w_shr[BITWIDTH-1:0];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vector_mac_reduction_tree.sv
// +----------------------------------------------------------------------------+
// | tb_vector_mac_reduction_tree                                               |
// | Directed bench with a packet-level dot-product model for N=8 and N=5.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vector_mac_reduction_tree;

    localparam int LAT = 6;

    logic               clk = 1'b0;
    logic               rstn;
    logic [8*16-1:0]    in0_8, in1_8;
    logic [5*16-1:0]    in0_5, in1_5;
    logic               v8, v5, in_last, acc_en;
    logic [15:0]        out8, out5, beats8, beats5;
    logic               ov8, ov5, sat8, sat5;

    always #5 clk = ~clk;

    vector_mac_reduction_tree #(.BITWIDTH(16), .N(8), .FRAC(8), .ACC_WIDTH(48)) dut8 (
        .clk(clk), .rstn(rstn), .in0(in0_8), .in1(in1_8), .in_valid(v8),
        .in_last(in_last), .acc_en(acc_en), .out(out8), .out_valid(ov8),
        .out_sat(sat8), .out_beats(beats8));

    vector_mac_reduction_tree #(.BITWIDTH(16), .N(5), .FRAC(8), .ACC_WIDTH(48)) dut5 (
        .clk(clk), .rstn(rstn), .in0(in0_5), .in1(in1_5), .in_valid(v5),
        .in_last(in_last), .acc_en(acc_en), .out(out5), .out_valid(ov5),
        .out_sat(sat5), .out_beats(beats5));

    typedef struct {
        int          id;
        int          due;
        logic [15:0] o;
        bit          s;
        int          b;
    } exp_t;

    exp_t               q[$];
    int                 cyc = 0;
    int                 n_checks = 0;
    int                 n_errors = 0;
    logic signed [15:0] la [8];
    logic signed [15:0] lb [8];
    longint             m_acc [2];
    int                 m_beats [2];
    bit                 m_inpkt [2];
    logic [15:0]        e_o [2];
    bit                 e_s [2];
    int                 e_b [2];
    logic [15:0]        d_o [2];
    bit                 d_s [2];
    int                 d_b [2];
    int                 strobes [2];
    int                 strobe_cyc [2];
    int                 beat_edge;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Packet rules in plain integer arithmetic; a finished packet is queued with its due cycle.
    task automatic beat(input int id, input bit last_i, input bit ae_i);
        longint dot;
        longint r;
        bit     fin;
        int     n;
        exp_t   e;
        @(negedge clk);
        n   = (id == 0) ? 8 : 5;
        dot = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) dot += longint'(la[i]) * longint'(lb[i]);
            in0_8[i*16 +: 16] = la[i];
            in1_8[i*16 +: 16] = lb[i];
        end
        for (int i = 0; i < 5; i++) begin
            in0_5[i*16 +: 16] = la[i];
            in1_5[i*16 +: 16] = lb[i];
        end
        v8        = (id == 0);
        v5        = (id == 1);
        in_last   = last_i;
        acc_en    = ae_i;
        beat_edge = cyc + 1;
        if (!m_inpkt[id]) begin
            m_acc[id]   = dot;
            m_beats[id] = 1;
            fin         = last_i || !ae_i;
            m_inpkt[id] = !fin;
        end else begin
            m_acc[id]   += dot;
            m_beats[id] += 1;
            fin         = last_i;
            m_inpkt[id] = !fin;
        end
        if (fin) begin
            r     = (m_acc[id] + 128) >>> 8;
            e.id  = id;
            e.due = cyc + 1 + LAT;
            e.s   = (r > 32767) || (r < -32768);
            e.o   = (r > 32767) ? 16'h7FFF : (r < -32768) ? 16'h8000 : r[15:0];
            e.b   = m_beats[id];
            q.push_back(e);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            v8      = 1'b0;
            v5      = 1'b0;
            in_last = 1'b0;
        end
    endtask

    task automatic set_all(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 8; i++) begin
            la[i] = a;
            lb[i] = b;
        end
    endtask

    task automatic set_lane0(input logic [15:0] a, input logic [15:0] b);
        set_all(16'h0000, 16'h0000);
        la[0] = a;
        lb[0] = b;
    endtask

    task automatic expect_lit(input string nm, input int id, input logic [15:0] o,
                              input bit s, input int b);
        chk({nm, "_out"}, d_o[id], o);
        chk({nm, "_sat"}, d_s[id], s);
        chk({nm, "_beats"}, d_b[id], b);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        a_v, a_s;
            logic [15:0] a_o, a_b;
            int          idx;
            a_v = (d == 0) ? ov8 : ov5;
            a_o = (d == 0) ? out8 : out5;
            a_s = (d == 0) ? sat8 : sat5;
            a_b = (d == 0) ? beats8 : beats5;
            if (!rstn) begin
                chk($sformatf("rst_valid%0d", d), a_v, 0);
                chk($sformatf("rst_out%0d", d), a_o, 0);
                chk($sformatf("rst_sat%0d", d), a_s, 0);
                chk($sformatf("rst_beats%0d", d), a_b, 0);
                e_o[d] = '0;
                e_s[d] = 1'b0;
                e_b[d] = 0;
            end else begin
                idx = -1;
                for (int k = 0; k < q.size(); k++) begin
                    if (idx < 0 && q[k].id == d && q[k].due == cyc) idx = k;
                end
                chk($sformatf("valid%0d", d), a_v, (idx >= 0));
                if (idx >= 0) begin
                    if (a_v) begin
                        chk($sformatf("out%0d", d), a_o, q[idx].o);
                        chk($sformatf("sat%0d", d), a_s, q[idx].s);
                        chk($sformatf("beats%0d", d), a_b, q[idx].b);
                        d_o[d] = a_o;
                        d_s[d] = a_s;
                        d_b[d] = a_b;
                        strobes[d]++;
                        strobe_cyc[d] = cyc;
                    end
                    e_o[d] = q[idx].o;
                    e_s[d] = q[idx].s;
                    e_b[d] = q[idx].b;
                    q.delete(idx);
                end else if (!a_v) begin
                    chk($sformatf("hold_out%0d", d), a_o, e_o[d]);
                    chk($sformatf("hold_sat%0d", d), a_s, e_s[d]);
                    chk($sformatf("hold_beats%0d", d), a_b, e_b[d]);
                end
            end
        end
    end

    initial begin
        int s0;
        rstn = 1'b0; v8 = 0; v5 = 0; in_last = 0; acc_en = 0;
        in0_8 = '0; in1_8 = '0; in0_5 = '0; in1_5 = '0;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_beats[d] = 0; m_inpkt[d] = 0;
            d_o[d] = '0; d_s[d] = 0; d_b[d] = 0; strobes[d] = 0; strobe_cyc[d] = 0;
        end
        set_all(16'h0000, 16'h0000);
        idle(3);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Single beat
        set_all(16'h0100, 16'h0200);
        beat(0, 1'b1, 1'b0);
        idle(8);
        expect_lit("single", 0, 16'h1000, 1'b0, 1);
        chk("single_latency", strobe_cyc[0] - beat_edge, 6);

        // Accumulate with a bubble; acc_en after the first beat is ignored
        s0 = strobes[0];
        beat(0, 1'b0, 1'b1);
        idle(2);
        beat(0, 1'b0, 1'b0);
        beat(0, 1'b1, 1'b0);
        idle(8);
        expect_lit("accum", 0, 16'h3000, 1'b0, 3);
        chk("accum_latency", strobe_cyc[0] - beat_edge, 6);
        chk("accum_strobes", strobes[0] - s0, 1);

        // Saturation both ways
        set_all(16'h7FFF, 16'h7FFF);
        beat(0, 1'b1, 1'b1);
        idle(8);
        expect_lit("sat_pos", 0, 16'h7FFF, 1'b1, 1);
        set_all(16'h8000, 16'h7FFF);
        beat(0, 1'b1, 1'b1);
        idle(8);
        expect_lit("sat_neg", 0, 16'h8000, 1'b1, 1);

        // Rounding half-up
        set_lane0(16'h0001, 16'h0080);
        beat(0, 1'b1, 1'b0);
        idle(8);
        expect_lit("round_pos", 0, 16'h0001, 1'b0, 1);
        set_lane0(16'hFFFF, 16'h0080);
        beat(0, 1'b1, 1'b0);
        idle(8);
        expect_lit("round_neg", 0, 16'h0000, 1'b0, 1);

        // Per-beat mode, back-to-back strobes
        s0 = strobes[0];
        for (int k = 1; k <= 4; k++) begin
            set_lane0(16'h0100, 16'(k * 256));
            beat(0, 1'b0, 1'b0);
        end
        idle(8);
        chk("perbeat_strobes", strobes[0] - s0, 4);
        expect_lit("perbeat_last", 0, 16'h0400, 1'b0, 1);

        // Reset in the middle of a 4-beat packet
        s0 = strobes[0];
        set_all(16'h0100, 16'h0100);
        beat(0, 1'b0, 1'b1);
        beat(0, 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        q.delete();
        m_inpkt[0] = 0;
        m_inpkt[1] = 0;
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        idle(10);
        chk("rst_no_strobe", strobes[0] - s0, 0);

        // N = 5 instance
        set_all(16'h0100, 16'h0100);
        beat(1, 1'b1, 1'b0);
        idle(8);
        expect_lit("n5", 1, 16'h0500, 1'b0, 1);
        chk("n5_latency", strobe_cyc[1] - beat_edge, 6);

        idle(2);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
